// File: rtl/board_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
// Shared board-level definitions for the push-button conditioning logic.
//   CLK_HZ_DEFAULT : nominal sys_clk frequency in Hz
//   btn_state_t    : per-channel debounce FSM state
//   ms_to_cyc()    : converts a duration in milliseconds to sys_clk cycles
// -----------------------------------------------------------------------------
package board_pkg;

    localparam int CLK_HZ_DEFAULT = 27_000_000;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Divide first so that large clock rates times long durations stay in 32 bits.
    function automatic int ms_to_cyc(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
// One push-button channel: 2-flop synchroniser, debounce FSM, hold counter for
// long-press detection and (with BTN_AUTOREPEAT_EN defined) an auto-repeat
// counter that re-issues press pulses while the button stays held.
// Parameters:
//   DB_CYC   : consecutive stable samples needed to accept a level change (>= 2)
//   LONG_CYC : cycles held in PRESSED before btn_long fires
//   RPT_CYC  : auto-repeat period (only with BTN_AUTOREPEAT_EN)
// Ports:
//   sys_clk     in  : system clock
//   sys_rst     in  : synchronous reset, active-high
//   btn_n_in    in  : raw active-low pin, asynchronous to sys_clk
//   btn_level_n out : debounced level, active-low
//   btn_press   out : 1-cycle pulse on accepted press (and on auto-repeat)
//   btn_release out : 1-cycle pulse on accepted release
//   btn_long    out : 1-cycle pulse once per press after LONG_CYC of holding
// -----------------------------------------------------------------------------
module btn_debounce_ch
    import board_pkg::*;
#(
    parameter int DB_CYC   = 4,
    parameter int LONG_CYC = 10
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int RPT_CYC  = 3
`endif
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic btn_n_in,
    output logic btn_level_n,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int DB_W   = $clog2(DB_CYC) + 1;
    localparam int HOLD_W = $clog2(LONG_CYC) + 1;

    localparam logic [DB_W-1:0]   DB_ZERO   = {DB_W{1'b0}};
    localparam logic [DB_W-1:0]   DB_ONE    = {{(DB_W-1){1'b0}}, 1'b1};
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(RPT_CYC) + 1;
    localparam logic [RPT_W-1:0] RPT_ZERO = {RPT_W{1'b0}};
    localparam logic [RPT_W-1:0] RPT_ONE  = {{(RPT_W-1){1'b0}}, 1'b1};
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(RPT_CYC - 1);

    logic [RPT_W-1:0] rpt_cnt_r;
`endif

    logic              sync1_r;
    logic              sync2_r;
    btn_state_t        state_r;
    logic [DB_W-1:0]   db_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              level_n_r;
    logic              press_r;
    logic              release_r;
    logic              long_r;

    // Two-flop synchroniser; resets to the released (high) level.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= btn_n_in;
            sync2_r <= sync1_r;
        end
    end

    // Debounce FSM with hold/repeat counters and registered event pulses.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r    <= RELEASED;
            db_cnt_r   <= DB_ZERO;
            hold_cnt_r <= HOLD_ZERO;
            level_n_r  <= 1'b1;
            press_r    <= 1'b0;
            release_r  <= 1'b0;
            long_r     <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_cnt_r  <= RPT_ZERO;
`endif
        end else begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
            long_r    <= 1'b0;
            case (state_r)
                RELEASED: begin
                    if (!sync2_r) begin
                        state_r  <= PRESS_WAIT;
                        db_cnt_r <= DB_ONE;
                    end else begin
                        db_cnt_r <= DB_ZERO;
                    end
                end
                PRESS_WAIT: begin
                    if (sync2_r) begin
                        state_r  <= RELEASED;
                        db_cnt_r <= DB_ZERO;
                    end else if (db_cnt_r == DB_LAST) begin
                        state_r    <= PRESSED;
                        db_cnt_r   <= DB_ZERO;
                        hold_cnt_r <= HOLD_ZERO;
                        level_n_r  <= 1'b0;
                        press_r    <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        rpt_cnt_r  <= RPT_ZERO;
`endif
                    end else begin
                        db_cnt_r <= db_cnt_r + DB_ONE;
                    end
                end
                PRESSED: begin
                    if (sync2_r) begin
                        state_r  <= RELEASE_WAIT;
                        db_cnt_r <= DB_ONE;
                    end else begin
                        // hold_cnt saturates at LONG_CYC, so equality with
                        // LONG_CYC-1 is seen only once per press.
                        if (hold_cnt_r == HOLD_LAST) begin
                            long_r <= 1'b1;
                        end else begin
                            long_r <= 1'b0;
                        end
                        if (hold_cnt_r != HOLD_MAX) begin
                            hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                        end else begin
                            hold_cnt_r <= hold_cnt_r;
                        end
`ifdef BTN_AUTOREPEAT_EN
                        // Saturated hold count means btn_long has already fired.
                        if (hold_cnt_r == HOLD_MAX) begin
                            if (rpt_cnt_r == RPT_LAST) begin
                                press_r   <= 1'b1;
                                rpt_cnt_r <= RPT_ZERO;
                            end else begin
                                rpt_cnt_r <= rpt_cnt_r + RPT_ONE;
                            end
                        end else begin
                            rpt_cnt_r <= rpt_cnt_r;
                        end
`endif
                    end
                end
                RELEASE_WAIT: begin
                    // hold_cnt (and rpt_cnt) are kept, so a release bounce
                    // neither re-arms btn_long nor restarts the repeat phase.
                    if (!sync2_r) begin
                        state_r  <= PRESSED;
                        db_cnt_r <= DB_ZERO;
                    end else if (db_cnt_r == DB_LAST) begin
                        state_r   <= RELEASED;
                        db_cnt_r  <= DB_ZERO;
                        level_n_r <= 1'b1;
                        release_r <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        rpt_cnt_r <= RPT_ZERO;
`endif
                    end else begin
                        db_cnt_r <= db_cnt_r + DB_ONE;
                    end
                end
                default: begin
                    state_r   <= RELEASED;
                    db_cnt_r  <= DB_ZERO;
                    level_n_r <= 1'b1;
                end
            endcase
        end
    end

    assign btn_level_n = level_n_r;
    assign btn_press   = press_r;
    assign btn_release = release_r;
    assign btn_long    = long_r;

endmodule

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Push-button conditioning: synchronises, debounces and edge-detects NUM_BTN
// raw active-low pins, with per-button long-press detection. Define
// BTN_AUTOREPEAT_EN to make btn_press repeat every REPEAT_MS after btn_long
// while the button stays held.
// Ports:
//   sys_clk     in  1       : system clock (single domain)
//   sys_rst     in  1       : synchronous reset, active-high
//   btn_n_in    in  NUM_BTN : raw active-low pins, asynchronous
//   btn_level_n out NUM_BTN : debounced level, active-low (0 = pressed)
//   btn_press   out NUM_BTN : 1-cycle pulse on accepted press
//   btn_release out NUM_BTN : 1-cycle pulse on accepted release
//   btn_long    out NUM_BTN : 1-cycle pulse after LONG_MS of holding
// -----------------------------------------------------------------------------
module btn_debounce
    import board_pkg::*;
#(
    parameter int NUM_BTN     = 2,
    parameter int CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [NUM_BTN-1:0] btn_n_in,
    output logic [NUM_BTN-1:0] btn_level_n,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    localparam int DB_CYC   = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
    localparam int LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);
`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_CYC  = ms_to_cyc(CLK_HZ, REPEAT_MS);
`endif

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYC   (DB_CYC),
            .LONG_CYC (LONG_CYC)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .RPT_CYC  (RPT_CYC)
`endif
        ) u_ch (
            .sys_clk     (sys_clk),
            .sys_rst     (sys_rst),
            .btn_n_in    (btn_n_in[g]),
            .btn_level_n (btn_level_n[g]),
            .btn_press   (btn_press[g]),
            .btn_release (btn_release[g]),
            .btn_long    (btn_long[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
// Directed scenarios followed by randomized pin activity, all compared every
// cycle against a behavioural model built from run-lengths of synchronised
// samples: a level flips after DB_CYC consecutive opposing samples, btn_long
// fires on the LONG_CYC-th held sample, repeats every RPT_CYC samples after.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

    localparam int NUM_BTN  = 2;
    localparam int DB_CYC   = 4;
    localparam int LONG_CYC = 10;
    localparam int RPT_CYC  = 3;

    logic               sys_clk = 1'b0;
    logic               sys_rst;
    logic [NUM_BTN-1:0] btn_n_in;
    logic [NUM_BTN-1:0] btn_level_n;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_long;

    btn_debounce #(
        .NUM_BTN     (NUM_BTN),
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (4),
        .LONG_MS     (10),
        .REPEAT_MS   (3)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .btn_n_in    (btn_n_in),
        .btn_level_n (btn_level_n),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    // Reference model state
    logic m_pipe    [NUM_BTN][2];   // [0] = value the debouncer sees this edge
    bit   m_pressed [NUM_BTN];
    int   m_run     [NUM_BTN];      // consecutive samples opposing the level
    int   m_hold    [NUM_BTN];      // held samples since press (saturating)
    int   m_after   [NUM_BTN];      // held samples after btn_long fired
    logic [NUM_BTN-1:0] exp_level_n, exp_press, exp_release, exp_long;

    int   n_long_seen = 0;
    int   n_press_seen = 0;

    task automatic model_edge();
        exp_press   = '0;
        exp_release = '0;
        exp_long    = '0;
        for (int c = 0; c < NUM_BTN; c++) begin
            logic s;
            if (sys_rst) begin
                m_pipe[c][0] = 1'b1;
                m_pipe[c][1] = 1'b1;
                m_pressed[c] = 1'b0;
                m_run[c]     = 0;
                m_hold[c]    = 0;
                m_after[c]   = 0;
            end else begin
                s = m_pipe[c][0];
                m_pipe[c][0] = m_pipe[c][1];
                m_pipe[c][1] = btn_n_in[c];
                if (!m_pressed[c]) begin
                    if (s == 1'b0) begin
                        m_run[c]++;
                        if (m_run[c] == DB_CYC) begin
                            m_pressed[c] = 1'b1;
                            m_run[c]     = 0;
                            m_hold[c]    = 0;
                            m_after[c]   = 0;
                            exp_press[c] = 1'b1;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end else begin
                    if (s == 1'b1) begin
                        m_run[c]++;
                        if (m_run[c] == DB_CYC) begin
                            m_pressed[c]   = 1'b0;
                            m_run[c]       = 0;
                            exp_release[c] = 1'b1;
                        end
                    end else if (m_run[c] > 0) begin
                        m_run[c] = 0;        // release bounce: back to held, not counted
                    end else if (m_hold[c] < LONG_CYC) begin
                        m_hold[c]++;
                        if (m_hold[c] == LONG_CYC) exp_long[c] = 1'b1;
                    end else begin
                        m_after[c]++;
`ifdef BTN_AUTOREPEAT_EN
                        if (m_after[c] % RPT_CYC == 0) exp_press[c] = 1'b1;
`endif
                    end
                end
            end
            exp_level_n[c] = ~m_pressed[c];
        end
    endtask

    task automatic check(input string tag, input logic [NUM_BTN-1:0] got,
                         input logic [NUM_BTN-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic tick();
        @(posedge sys_clk);
        model_edge();
        cyc++;
        @(negedge sys_clk);
        check("level_n", btn_level_n, exp_level_n);
        check("press",   btn_press,   exp_press);
        check("release", btn_release, exp_release);
        check("long",    btn_long,    exp_long);
        n_long_seen  += $countones(btn_long);
        n_press_seen += $countones(btn_press);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int timer [NUM_BTN];
    int rst_left;

    initial begin
        sys_rst  = 1'b1;
        btn_n_in = 2'b11;
        for (int c = 0; c < NUM_BTN; c++) begin
            m_pipe[c][0] = 1'b1; m_pipe[c][1] = 1'b1;
            m_pressed[c] = 1'b0; m_run[c] = 0; m_hold[c] = 0; m_after[c] = 0;
        end

        // 1. Reset with both buttons held, then re-detection after deassert
        btn_n_in = 2'b00;
        run(3);
        check("reset_level_n", btn_level_n, 2'b11);
        sys_rst = 1'b0;
        run(12);
        check("held_through_reset", btn_level_n, 2'b00);
        btn_n_in = 2'b11;
        run(10);

        // 2. Clean press/release on channel 0
        btn_n_in = 2'b10;
        run(8);
        btn_n_in = 2'b11;
        run(10);

        // 3. Bounce on channel 0: toggles every 2 cycles, then settles high
        for (int i = 0; i < 10; i++) begin
            btn_n_in[0] = ~btn_n_in[0];
            run(2);
        end
        btn_n_in = 2'b11;
        run(8);
        check("bounce_level_n", btn_level_n, 2'b11);

        // 4. Long press on channel 1
        n_long_seen = 0;
        btn_n_in = 2'b01;
        run(20);
        btn_n_in = 2'b11;
        run(10);
        assert (n_long_seen == 1) else begin
            n_fails++;
            $error("FAIL long_once observed=%0d expected=1", n_long_seen);
        end
        n_checks++;

        // 5. Simultaneous press, then a glitch on 0 during 1's debounce
        btn_n_in = 2'b00;
        run(8);
        btn_n_in = 2'b11;
        run(10);
        btn_n_in = 2'b01;
        tick();
        btn_n_in = 2'b00;
        tick();
        btn_n_in = 2'b01;
        run(10);
        btn_n_in = 2'b11;
        run(10);

        // 6. Reset while channel 0 is pressed
        btn_n_in = 2'b10;
        run(8);
        sys_rst = 1'b1;
        tick();
        check("rst_mid_press_level", btn_level_n, 2'b11);
        btn_n_in = 2'b11;
        run(2);
        sys_rst = 1'b0;
        run(15);

        // Randomized pin activity with occasional resets
        rst_left = 0;
        for (int c = 0; c < NUM_BTN; c++) timer[c] = $urandom_range(1, 20);
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NUM_BTN; c++) begin
                if (timer[c] == 0) begin
                    btn_n_in[c] = ~btn_n_in[c];
                    if ($urandom_range(0, 2) == 0) timer[c] = $urandom_range(1, 3);
                    else timer[c] = $urandom_range(4, 30);
                end else begin
                    timer[c]--;
                end
            end
            if (rst_left > 0) begin
                sys_rst = 1'b1;
                rst_left--;
            end else begin
                sys_rst = 1'b0;
                if ($urandom_range(0, 499) == 0) rst_left = $urandom_range(1, 3);
            end
            tick();
        end
        sys_rst  = 1'b0;
        btn_n_in = 2'b11;
        run(12);
        check("final_level_n", btn_level_n, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
